// File: rtl/encode_gen_pkg.sv
// Shared constants, FSM encoding and modulus arithmetic for the NTRU Prime encoder.
package encode_gen_pkg;

    localparam int RP_DEPTH_DEF  = 10;
    localparam int RP_D_SIZE_DEF = 14;
    localparam int EMIT_THRESH   = 16384;
    localparam int ROUND_UP      = 255;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        EMIT,
        STORE,
        FINAL,
        DONE
    } state_t;

    // One byte-emit step: the modulus shrinks by 256, rounded up.
    function automatic logic [31:0] mod_step(input logic [31:0] m);
        return (m + 32'(ROUND_UP)) >> 8;
    endfunction

    // Modulus left after all emit steps of one pair; two steps always suffice.
    function automatic logic [31:0] mod_reduce(input logic [31:0] m);
        logic [31:0] v;
        v = m;
        for (int k = 0; k < 2; k++) begin
            if (v >= 32'(EMIT_THRESH)) v = mod_step(v);
        end
        return v;
    endfunction

endpackage

// File: rtl/bram_p.sv
// Simple dual-port RAM, one write and one registered read port, write-first on collision.
module bram_p #(
    parameter int D_SIZE  = 14,
    parameter int Q_DEPTH = 9
) (
    input  logic               clk,
    input  logic               wen,
    input  logic [Q_DEPTH-1:0] waddr,
    input  logic [D_SIZE-1:0]  wdata,
    input  logic [Q_DEPTH-1:0] raddr,
    output logic [D_SIZE-1:0]  rdata
);

    logic [D_SIZE-1:0] mem [2**Q_DEPTH];

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (wen && (waddr == raddr)) rdata <= wdata;
        else                         rdata <= mem[raddr];
    end

endmodule

// File: rtl/encode_gen.sv
// NTRU Prime Encode engine: pairwise merge rounds over an in-place buffer, bytes out on a valid/ready port.
// state | meaning
// IDLE  | waiting for start
// LOAD  | reading the two operands of a pair (or the odd tail / the last element)
// MERGE | forming r and its modulus
// EMIT  | sending r[7:0] while the modulus is >= 16384
// STORE | writing the reduced value back and stepping pair/round
// FINAL | draining the single remaining value
// DONE  | one-cycle completion pulse
module encode_gen
    import encode_gen_pkg::*;
#(
    parameter int RP_DEPTH  = RP_DEPTH_DEF,
    parameter int RP_D_SIZE = RP_D_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [RP_DEPTH:0]   n_in,
    input  logic [RP_D_SIZE:0]  m_in,
    output logic [RP_DEPTH-1:0] rp_rd_addr,
    input  logic [RP_D_SIZE-1:0] rp_rd_data,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int W  = RP_D_SIZE;
    localparam int NW = RP_DEPTH + 1;
    localparam int MW = RP_D_SIZE + 1;
    localparam int PW = 2 * RP_D_SIZE + 1;

    state_t                state, state_next;
    logic [NW-1:0]         n_cur;
    logic [MW-1:0]         mm, mt;
    logic [RP_DEPTH-1:0]   i_idx, i_inc, rd_addr;
    logic [1:0]            ld_cnt;
    logic                  round1, tail;
    logic [W-1:0]          a, b, src_data, buf_rdata;
    logic [2*W-1:0]        r, merge_r;
    logic [PW-1:0]         mod, merge_mod, step_mod;
    logic                  last_pair, out_valid_i;

    assign i_inc     = i_idx + 1'b1;
    assign last_pair = (({1'b0, i_idx} + 1'b1) == (n_cur >> 1));
    assign src_data  = round1 ? rp_rd_data : buf_rdata;
    assign step_mod  = PW'(mod_step(32'(mod)));
    // The last pair of an even round carries the tail modulus in its upper operand.
    assign merge_mod = tail ? PW'(mt)
                            : PW'(mm) * PW'((last_pair && !n_cur[0]) ? mt : mm);
    assign merge_r   = tail ? (2*W)'(a) : (2*W)'(a) + (2*W)'(mm) * (2*W)'(b);

    bram_p #(.D_SIZE(W), .Q_DEPTH(RP_DEPTH-1)) u_buf (
        .clk   (clk),
        .wen   (state == STORE),
        .waddr (i_idx[RP_DEPTH-2:0]),
        .wdata (r[W-1:0]),
        .raddr (rd_addr[RP_DEPTH-2:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_next  = state;
        out_valid_i = 1'b0;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD: begin
                if (ld_cnt == 2'd1 && n_cur == NW'(1))             state_next = FINAL;
                else if ((ld_cnt == 2'd1 && tail) || ld_cnt == 2'd2) state_next = MERGE;
            end
            MERGE: state_next = (merge_mod >= PW'(EMIT_THRESH)) ? EMIT : STORE;
            EMIT: begin
                out_valid_i = 1'b1;
                if (out_ready) state_next = (step_mod >= PW'(EMIT_THRESH)) ? EMIT : STORE;
            end
            STORE: state_next = LOAD;
            FINAL: begin
                if (mod > PW'(1)) begin
                    out_valid_i = 1'b1;
                    if (out_ready && step_mod <= PW'(1)) state_next = DONE;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_cur   <= '0;
            mm      <= '0;
            mt      <= '0;
            i_idx   <= '0;
            rd_addr <= '0;
            ld_cnt  <= '0;
            round1  <= 1'b0;
            tail    <= 1'b0;
            a       <= '0;
            b       <= '0;
            r       <= '0;
            mod     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    n_cur   <= n_in;
                    mm      <= m_in;
                    mt      <= m_in;
                    i_idx   <= '0;
                    rd_addr <= '0;
                    ld_cnt  <= '0;
                    round1  <= 1'b1;
                    tail    <= 1'b0;
                end
                LOAD: begin
                    ld_cnt <= (state_next == LOAD) ? ld_cnt + 2'd1 : 2'd0;
                    if (ld_cnt == 2'd0 && !tail && n_cur != NW'(1)) rd_addr <= rd_addr + 1'b1;
                    if (ld_cnt == 2'd1) begin
                        a   <= src_data;
                        r   <= (2*W)'(src_data);
                        mod <= PW'(mt);
                    end
                    if (ld_cnt == 2'd2) b <= src_data;
                end
                MERGE: begin
                    r   <= merge_r;
                    mod <= merge_mod;
                end
                EMIT, FINAL: if (out_valid_i && out_ready) begin
                    r   <= r >> 8;
                    mod <= step_mod;
                end
                STORE: begin
                    if (!tail && last_pair && !n_cur[0]) mt <= MW'(mod);
                    if (!tail && !last_pair) begin
                        i_idx   <= i_inc;
                        rd_addr <= {i_inc[RP_DEPTH-2:0], 1'b0};
                    end else if (!tail && n_cur[0]) begin
                        tail    <= 1'b1;
                        i_idx   <= i_inc;
                        rd_addr <= RP_DEPTH'(n_cur - 1);
                    end else begin
                        n_cur   <= NW'((n_cur + 1) >> 1);
                        mm      <= MW'(mod_reduce(32'(mm) * 32'(mm)));
                        round1  <= 1'b0;
                        tail    <= 1'b0;
                        i_idx   <= '0;
                        rd_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = rst_n && out_valid_i;
    assign out_data   = out_valid ? r[7:0] : 8'd0;
    assign busy       = rst_n && (state != IDLE);
    assign done       = rst_n && (state == DONE);
    assign rp_rd_addr = rst_n ? rd_addr : '0;

endmodule

// File: tb/tb_encode_gen.sv
// Bench for encode_gen: directed and random encodes compared with a list-based software Encode model.
module tb_encode_gen;

    localparam int D = 10;
    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n, start, out_ready;
    logic [D:0]   n_in;
    logic [W:0]   m_in;
    logic [D-1:0] rp_rd_addr;
    logic [W-1:0] rp_rd_data;
    logic [7:0]   out_data;
    logic         out_valid, busy, done;

    always #5 clk = ~clk;

    encode_gen #(.RP_DEPTH(D), .RP_D_SIZE(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_in       (n_in),
        .m_in       (m_in),
        .rp_rd_addr (rp_rd_addr),
        .rp_rd_data (rp_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    logic [W-1:0] src_mem [1024];
    always @(posedge clk) rp_rd_data <= src_mem[rp_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    byte unsigned got_q[$];
    int done_cnt = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            last_xfer_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    byte unsigned exp_q[$];
    int last_base = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    // Software Encode over explicit value/modulus lists.
    task automatic model(input int n, input int m);
        longint rr[$], mq[$], r2[$], m2[$];
        longint r, mo;
        int cnt;
        cnt = n;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            rr.push_back(longint'(src_mem[k]));
            mq.push_back(longint'(m));
        end
        while (cnt > 1) begin
            r2.delete();
            m2.delete();
            for (int k = 0; k + 1 < cnt; k += 2) begin
                r  = rr[k] + mq[k] * rr[k+1];
                mo = mq[k] * mq[k+1];
                while (mo >= 16384) begin
                    exp_q.push_back(8'(r));
                    r  = r >> 8;
                    mo = (mo + 255) >> 8;
                end
                r2.push_back(r);
                m2.push_back(mo);
            end
            if (cnt % 2 == 1) begin
                r2.push_back(rr[cnt-1]);
                m2.push_back(mq[cnt-1]);
            end
            rr  = r2;
            mq  = m2;
            cnt = (cnt + 1) / 2;
        end
        r  = rr[0];
        mo = mq[0];
        while (mo > 1) begin
            exp_q.push_back(8'(r));
            r  = r >> 8;
            mo = (mo + 255) >> 8;
        end
    endtask

    task automatic fill_random(input int n, input int m);
        for (int k = 0; k < n; k++) src_mem[k] = W'($urandom_range(0, m - 1));
    endtask

    task automatic do_stall();
        logic [7:0] held;
        int k;
        k = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_wait", out_valid, 1);
        held = out_data;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    // mode bit0: random out_ready, bit1: 10-cycle stall, bit2: start pulse while busy
    task automatic run_encode(input int n, input int m, input logic [2:0] mode, input string tag);
        int dbase, cycles, mism;
        model(n, m);
        last_base = got_q.size();
        dbase     = done_cnt;
        n_in      = (D+1)'(n);
        m_in      = (W+1)'(m);
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        while (done_cnt == dbase && cycles < 60000) begin
            start     = mode[2] && (cycles == 50);
            out_ready = mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode[1] && cycles == 300) do_stall();
            @(posedge clk); #1;
            cycles++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mism = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (got_at(last_base + k) !== exp_q[k]) mism++;
        check({tag, "_done_cnt"}, done_cnt - dbase, 1);
        check({tag, "_count"}, got_q.size() - last_base, exp_q.size());
        check({tag, "_bytes"}, mism, 0);
        check({tag, "_done_gap"}, done_cyc - last_xfer_cyc, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        start     = 1'b0;
        n_in      = '0;
        m_in      = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 1024; k++) src_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rp_rd_addr, 0);
        check("rst_data", out_data, 0);

        // start while reset is held must be ignored
        n_in  = 5;
        m_in  = 4591;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_start_busy", busy, 0);
        check("rst_start_bytes", got_q.size(), 0);

        src_mem[0] = 14'd1234;
        run_encode(1, 4591, 3'b000, "n1");
        check("n1_byte0", got_at(last_base), 8'hD2);
        check("n1_byte1", got_at(last_base + 1), 8'h04);

        src_mem[0] = 14'd2;
        src_mem[1] = 14'd1;
        run_encode(2, 3, 3'b000, "n2");
        check("n2_byte0", got_at(last_base), 8'h05);

        fill_random(3, 4591);
        run_encode(3, 4591, 3'b000, "n3");

        fill_random(761, 4591);
        run_encode(761, 4591, 3'b000, "n761");
        check("n761_total", got_q.size() - last_base, 1158);
        run_encode(761, 4591, 3'b110, "n761_stall");
        check("n761_stall_total", got_q.size() - last_base, 1158);

        fill_random(761, 1531);
        run_encode(761, 1531, 3'b001, "n761_m1531");
        check("n761_m1531_total", got_q.size() - last_base, 1007);

        fill_random(8, 16384);
        run_encode(8, 16384, 3'b001, "m_max");

        fill_random(1024, 4591);
        run_encode(1024, 4591, 3'b000, "n_max");

        for (int t = 0; t < 4; t++) begin
            int n, m;
            n = $urandom_range(1, 40);
            m = $urandom_range(2, 16384);
            fill_random(n, m);
            run_encode(n, m, 3'b001, "rand");
        end

        // reset pulse mid-encode
        fill_random(761, 4591);
        n_in  = 761;
        m_in  = 4591;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        base = got_q.size();
        repeat (100) @(posedge clk);
        #1;
        check("midrst_no_bytes", got_q.size() - base, 0);
        check("midrst_idle", busy, 0);

        fill_random(100, 4591);
        run_encode(100, 4591, 3'b000, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encode_gen.md
ENCODE_GEN -- requirements
Module: encode_gen

Interface
REQ-001 Parameter RP_DEPTH, default 10: address width of the coefficient source; supports n up to 2^RP_DEPTH.
REQ-002 Parameter RP_D_SIZE, default 14: coefficient and modulus width; every modulus is at most 2^RP_D_SIZE.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse that launches an encode; ignored while busy=1.
REQ-006 Port n_in, input, RP_DEPTH+1: coefficient count n, 1..2^RP_DEPTH; sampled on start.
REQ-007 Port m_in, input, RP_D_SIZE+1: common initial modulus m, 2..16384; sampled on start.
REQ-008 Port rp_rd_addr, output, RP_DEPTH: coefficient source read address.
REQ-009 Port rp_rd_data, input, RP_D_SIZE: source data, valid one cycle after rp_rd_addr.
REQ-010 Port out_data, output, 8: encoded byte.
REQ-011 Port out_valid, output, 1: out_data valid.
REQ-012 Port out_ready, input, 1: sink accepts; a byte transfers when out_valid=1 and out_ready=1.
REQ-013 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-014 Port done, output, 1: one-cycle pulse, one cycle after the final byte transfers.

Function
REQ-015 The block SHALL implement the NTRU Prime Encode recursion with a main modulus mm and a tail modulus mt, both initialised to m_in.
REQ-016 Each round with n>1 SHALL merge pairs i=0..floor(n/2)-1 as r=R[2i]+M*R[2i+1], using a 2*RP_D_SIZE-bit product, where M=mm for every pair.
REQ-017 The merged modulus SHALL be mm*mm for every pair except the last pair when n is even, which SHALL use mm*mt.
REQ-018 For each merged pair, while its modulus is >=16384 the block SHALL emit r[7:0], then set r=r>>8 and modulus=(modulus+255)>>8; byte order SHALL follow ascending i.
REQ-019 When n is odd, R[n-1] SHALL pass unchanged to position (n-1)/2 and mt SHALL stay unchanged; otherwise mt SHALL become the reduced last-pair modulus.
REQ-020 After each round, mm SHALL become the reduced mm*mm and n SHALL become ceil(n/2).
REQ-021 In round 1 data SHALL come from rp_rd_data; later rounds SHALL read and write an internal buffer of 2^(RP_DEPTH-1) entries in place.
REQ-022 A same-address read and write in the same cycle SHALL return the written data.
REQ-023 When n=1, the block SHALL emit r[7:0], r=r>>8, mt=(mt+255)>>8 while mt>1, then pulse done.
REQ-024 FSM states: IDLE, LOAD, MERGE, EMIT, STORE, FINAL, DONE.
REQ-025 FSM transitions: IDLE->LOAD on start; LOAD->MERGE once both operands are valid; MERGE->EMIT when the modulus is >=16384, else MERGE->STORE.
REQ-026 FSM transitions: STORE->LOAD for the next pair, or a new round when the round is complete; entry with n=1 goes to FINAL; FINAL->DONE->IDLE.
REQ-027 When out_valid=1 and out_ready=0, out_data SHALL stay stable and the FSM SHALL stall; no byte SHALL be dropped or duplicated.
REQ-028 A pair SHALL need at most 2 emitted bytes, so no more than 2 EMIT beats per pair.
REQ-029 Total bytes SHALL be independent of out_ready timing.

Reset
REQ-030 While rst_n=0 the block SHALL enter IDLE and force out_valid=0, busy=0, done=0, rp_rd_addr=0, out_data=0; buffer contents are don't-care.
REQ-031 Reset asserted mid-encode SHALL abort the encode; no byte SHALL be emitted after rst_n rises until a new start.
REQ-032 A start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-033 Shared package: RP_DEPTH/RP_D_SIZE defaults, the 16384 emit threshold, the 255 round-up constant, and the FSM state encoding.
REQ-034 One sub-module: the existing bram_p dual-port RAM as the round buffer (D_SIZE=RP_D_SIZE, Q_DEPTH=RP_DEPTH-1).
REQ-035 Modulus update and byte-count logic SHALL be a function in the shared package, not a sub-module.

Verification
REQ-036 n=1, m=4591, R=[1234] -> bytes 0xD2, 0x04, then done.
REQ-037 n=2, m=3, R=[2,1] -> single byte 0x05.
REQ-038 n=761, m=4591, random R -> exactly 1158 bytes matching the software Encode.
REQ-039 n=761, m=1531 -> exactly 1007 bytes; n=3 odd-tail case also matches software.
REQ-040 Hold out_ready=0 for 10 cycles mid-stream -> out_data stable throughout, final stream identical to the out_ready=1 run.
REQ-041 rst_n=0 pulsed for 1 cycle mid-encode -> out_valid=0, busy=0, no further bytes; a following start encodes correctly.
